// File: rtl/hist_lut_builder.sv
// Histogram-equalization LUT builder: walks 256 histogram bins, accumulates the
// CDF and writes (cdf - cdf_min)*255 / (TOTAL_PIXEL - cdf_min) into the mapping LUT.
module hist_lut_builder #(
    parameter int W               = 64,
    parameter int H               = 64,
    parameter int TOTAL_PIXEL     = W * H,
    parameter int TOTAL_PIXEL_BIT = $clog2(W * H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 hist_addr,
    input  logic [TOTAL_PIXEL_BIT:0]   hist_data,
    output logic                       div_start,
    output logic [31:0]                div_dividend,
    output logic [TOTAL_PIXEL_BIT-1:0] div_divisor,
    input  logic                       div_done,
    input  logic [31:0]                div_quotient,
    output logic                       lut_we,
    output logic [7:0]                 lut_addr,
    output logic [7:0]                 lut_data
);
    localparam int CW = TOTAL_PIXEL_BIT + 1;
    localparam logic [CW-1:0] TOTAL_W = CW'(TOTAL_PIXEL);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RDW,
        ACC,
        DSTART,
        DWAIT,
        WR,
        FIN
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [7:0]    bin;
    logic [CW-1:0] cdf;
    logic [CW-1:0] cdf_min;
    logic          min_found;
    logic [7:0]    result;
    logic          armed;

    logic          first_hit;
    logic [CW-1:0] cdf_new;
    logic [CW-1:0] min_new;
    logic [CW-1:0] span_new;
    logic [31:0]   dividend_new;
    logic          bypass;

    // The quotient never exceeds 255, so only its low byte is consumed.
    logic unused_quotient_bits;
    assign unused_quotient_bits = ^div_quotient[31:8];

    assign hist_addr = bin;

    always_comb begin
        first_hit    = !min_found && (hist_data != '0);
        cdf_new      = cdf + hist_data;
        min_new      = first_hit ? hist_data : cdf_min;
        span_new     = TOTAL_W - min_new;
        dividend_new = 32'(cdf_new - min_new) * 32'd255;
        bypass       = (dividend_new == '0);
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        div_start  = 1'b0;
        lut_we     = 1'b0;
        lut_addr   = '0;
        lut_data   = '0;
        case (state)
            IDLE: begin
                if (start) state_next = RD;
            end
            RD: begin
                busy       = 1'b1;
                state_next = RDW;
            end
            RDW: begin
                busy       = 1'b1;
                state_next = ACC;
            end
            ACC: begin
                busy       = 1'b1;
                state_next = bypass ? WR : DSTART;
            end
            DSTART: begin
                busy       = 1'b1;
                div_start  = 1'b1;
                state_next = DWAIT;
            end
            DWAIT: begin
                busy = 1'b1;
                if (armed && div_done) state_next = WR;
            end
            WR: begin
                busy       = 1'b1;
                lut_we     = 1'b1;
                lut_addr   = bin;
                lut_data   = result;
                state_next = (bin == 8'hFF) ? FIN : RD;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            bin          <= '0;
            cdf          <= '0;
            cdf_min      <= '0;
            min_found    <= 1'b0;
            result       <= '0;
            armed        <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        cdf       <= '0;
                        cdf_min   <= '0;
                        min_found <= 1'b0;
                        bin       <= '0;
                    end
                end
                ACC: begin
                    cdf     <= cdf_new;
                    cdf_min <= min_new;
                    armed   <= 1'b0;
                    if (first_hit) min_found <= 1'b1;
                    // Operands are loaded here so they are already stable while DSTART pulses.
                    if (bypass) begin
                        result <= '0;
                    end else begin
                        div_dividend <= dividend_new;
                        div_divisor  <= span_new[TOTAL_PIXEL_BIT-1:0];
                    end
                end
                DWAIT: begin
                    // First DWAIT cycle leaves armed low so a stale div_done is skipped.
                    armed <= 1'b1;
                    if (armed && div_done) result <= div_quotient[7:0];
                end
                WR: begin
                    if (bin != 8'hFF) bin <= bin + 8'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_hist_lut_builder.sv
// Directed bench for hist_lut_builder: histogram RAM model, divider model with
// configurable latency and stale-done behaviour, and a LUT capture memory.
module tb_hist_lut_builder;
    localparam int CW = 13;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic [7:0]    hist_addr;
    logic [CW-1:0] hist_data = '0;
    logic          div_start;
    logic [31:0]   div_dividend;
    logic [11:0]   div_divisor;
    logic          div_done = 1'b0;
    logic [31:0]   div_quotient = '0;
    logic          lut_we;
    logic [7:0]    lut_addr;
    logic [7:0]    lut_data;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hist_lut_builder #(.W(64), .H(64)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .hist_addr(hist_addr), .hist_data(hist_data),
        .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_done(div_done), .div_quotient(div_quotient),
        .lut_we(lut_we), .lut_addr(lut_addr), .lut_data(lut_data)
    );

    logic [CW-1:0] hist_mem [256];
    always @(posedge clk) hist_data <= hist_mem[hist_addr];

    // Divider: result appears cnt edges after div_start; in stale mode done stays high
    // after a result until the edge following the next div_start.
    int          fixed_lat  = 1;
    bit          rand_lat   = 1'b0;
    bit          stale_mode = 1'b0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] q_pend = '0;
    always @(posedge clk) begin
        if (div_start) begin
            pend   <= 1'b1;
            q_pend <= div_dividend / {20'b0, div_divisor};
            cnt    <= rand_lat ? int'($urandom_range(40, 1)) : fixed_lat;
            if (!stale_mode) div_done <= 1'b0;
        end else if (pend) begin
            if (cnt <= 1) begin
                div_done     <= 1'b1;
                div_quotient <= q_pend;
                pend         <= 1'b0;
            end else begin
                div_done <= 1'b0;
                cnt      <= cnt - 1;
            end
        end else if (!stale_mode) begin
            div_done <= 1'b0;
        end
    end

    logic [7:0]  lut_mem [256];
    int          lut_stamp [256];
    int          run_id = 0;
    int          we_cnt = 0, ds_cnt = 0, done_cnt = 0, bad_div_cnt = 0;
    logic [11:0] exp_divisor = '0;
    logic [31:0] last_dividend = '0;
    logic [11:0] last_divisor = '0;
    always @(posedge clk) begin
        if (lut_we) begin
            lut_mem[lut_addr]   <= lut_data;
            lut_stamp[lut_addr] <= run_id;
            we_cnt              <= we_cnt + 1;
        end
        if (div_start) begin
            ds_cnt        <= ds_cnt + 1;
            last_dividend <= div_dividend;
            last_divisor  <= div_divisor;
            if (div_divisor !== exp_divisor) bad_div_cnt <= bad_div_cnt + 1;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic set_hist(input int a, input int ca, input int b, input int cb);
        for (int i = 0; i < 256; i++) hist_mem[i] = '0;
        hist_mem[a] = CW'(ca);
        hist_mem[b] = CW'(cb);
    endtask

    task automatic set_uniform();
        for (int i = 0; i < 256; i++) hist_mem[i] = CW'(16);
    endtask

    // Pulses start, then counts cycles (start edge = 1) until done is seen.
    task automatic run_build(input int max_cycles, input int extra_start, input bit start_in_fin,
                             output int cycles, output bit busy1, output bit timed_out);
        run_id = run_id + 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        busy1  = busy;
        cycles = 1;
        while (!done && cycles < max_cycles) begin
            @(negedge clk);
            cycles++;
            start = (cycles == extra_start);
        end
        timed_out = !done;
        start = start_in_fin;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if ({busy, done, div_start, lut_we} !== 4'b0) begin
            mismatched++;
            $display("FAIL reset_ctrl: got %b expected 0000", {busy, done, div_start, lut_we});
        end
        compared++;
        if (hist_addr !== 8'd0) begin
            mismatched++;
            $display("FAIL reset_hist_addr: got %0d expected 0", hist_addr);
        end
        compared++;
        if ({lut_addr, lut_data} !== 16'd0) begin
            mismatched++;
            $display("FAIL reset_lut_port: got %h expected 0", {lut_addr, lut_data});
        end
        compared++;
        if (div_dividend !== 32'd0 || div_divisor !== 12'd0) begin
            mismatched++;
            $display("FAIL reset_div_ops: got %0d/%0d expected 0/0", div_dividend, div_divisor);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_uniform();
        int cyc, we0, ds0, dn0, bd0;
        bit b1, to;
        set_uniform();
        fixed_lat = 1; rand_lat = 1'b0; stale_mode = 1'b0; exp_divisor = 12'd4080;
        we0 = we_cnt; ds0 = ds_cnt; dn0 = done_cnt; bd0 = bad_div_cnt;
        run_build(5000, 100, 1'b0, cyc, b1, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL uniform_timeout: done got 0 expected 1"); end
        compared++;
        if (b1 !== 1'b1) begin mismatched++; $display("FAIL uniform_busy: got %b expected 1", b1); end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== 8'(i) || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL uniform_lut[%0d]: got %0d expected %0d", i, lut_mem[i], i);
            end
        end
        compared++;
        if (we_cnt - we0 != 256) begin mismatched++; $display("FAIL uniform_we: got %0d expected 256", we_cnt - we0); end
        compared++;
        if (ds_cnt - ds0 != 255) begin mismatched++; $display("FAIL uniform_div_start: got %0d expected 255", ds_cnt - ds0); end
        compared++;
        if (done_cnt - dn0 != 1) begin mismatched++; $display("FAIL uniform_done: got %0d expected 1", done_cnt - dn0); end
        compared++;
        if (bad_div_cnt != bd0) begin mismatched++; $display("FAIL uniform_divisor: got %0d bad expected 0", bad_div_cnt - bd0); end
    endtask

    task automatic test_two_level();
        int cyc, we0, ds0, dn0, bd0;
        bit b1, to;
        set_hist(0, 2048, 255, 2048);
        exp_divisor = 12'd2048;
        we0 = we_cnt; ds0 = ds_cnt; dn0 = done_cnt; bd0 = bad_div_cnt;
        run_build(3000, 0, 1'b1, cyc, b1, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL two_level_timeout: done got 0 expected 1"); end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== ((i == 255) ? 8'd255 : 8'd0) || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL two_level_lut[%0d]: got %0d expected %0d", i, lut_mem[i], (i == 255) ? 255 : 0);
            end
        end
        compared++;
        if (ds_cnt - ds0 != 1) begin mismatched++; $display("FAIL two_level_div_start: got %0d expected 1", ds_cnt - ds0); end
        compared++;
        if (last_dividend !== 32'd522240 || last_divisor !== 12'd2048) begin
            mismatched++;
            $display("FAIL two_level_ops: got %0d/%0d expected 522240/2048", last_dividend, last_divisor);
        end
        compared++;
        if (we_cnt - we0 != 256) begin mismatched++; $display("FAIL two_level_we: got %0d expected 256", we_cnt - we0); end
        compared++;
        if (done_cnt - dn0 != 1 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL fin_start_ignored: done count %0d busy %b expected 1 and 0", done_cnt - dn0, busy);
        end
    endtask

    task automatic test_single_level();
        int cyc, ds0, dn0;
        bit b1, to;
        set_hist(100, 4096, 100, 4096);
        ds0 = ds_cnt; dn0 = done_cnt;
        run_build(3000, 0, 1'b0, cyc, b1, to);
        compared++;
        if (cyc != 1025) begin mismatched++; $display("FAIL single_latency: got %0d expected 1025", cyc); end
        compared++;
        if (ds_cnt != ds0) begin mismatched++; $display("FAIL single_div_start: got %0d expected 0", ds_cnt - ds0); end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== 8'd0 || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL single_lut[%0d]: got %0d expected 0", i, lut_mem[i]);
            end
        end
        compared++;
        if (done_cnt - dn0 != 1) begin mismatched++; $display("FAIL single_done: got %0d expected 1", done_cnt - dn0); end
    endtask

    task automatic test_sparse();
        int cyc, ds0, bd0;
        bit b1, to;
        set_hist(10, 1, 20, 4095);
        exp_divisor = 12'd4095;
        ds0 = ds_cnt; bd0 = bad_div_cnt;
        run_build(5000, 0, 1'b0, cyc, b1, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL sparse_timeout: done got 0 expected 1"); end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== ((i >= 20) ? 8'd255 : 8'd0) || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL sparse_lut[%0d]: got %0d expected %0d", i, lut_mem[i], (i >= 20) ? 255 : 0);
            end
        end
        compared++;
        if (ds_cnt - ds0 != 236) begin mismatched++; $display("FAIL sparse_div_start: got %0d expected 236", ds_cnt - ds0); end
        compared++;
        if (last_dividend !== 32'd1044225 || bad_div_cnt != bd0) begin
            mismatched++;
            $display("FAIL sparse_ops: dividend %0d bad divisors %0d expected 1044225 and 0", last_dividend, bad_div_cnt - bd0);
        end
    endtask

    task automatic test_random_latency();
        int cyc, ds0, dn0;
        bit b1, to;
        set_uniform();
        exp_divisor = 12'd4080;
        rand_lat = 1'b1; stale_mode = 1'b1;
        ds0 = ds_cnt; dn0 = done_cnt;
        run_build(20000, 0, 1'b0, cyc, b1, to);
        rand_lat = 1'b0; stale_mode = 1'b0;
        compared++;
        if (to) begin mismatched++; $display("FAIL rand_timeout: done got 0 expected 1"); end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== 8'(i) || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL rand_lut[%0d]: got %0d expected %0d", i, lut_mem[i], i);
            end
        end
        compared++;
        if (ds_cnt - ds0 != 255 || done_cnt - dn0 != 1) begin
            mismatched++;
            $display("FAIL rand_counts: div_start %0d done %0d expected 255 and 1", ds_cnt - ds0, done_cnt - dn0);
        end
    endtask

    task automatic test_reset_in_dwait();
        int cyc, ds0, dn0, we0, waited;
        bit b1, to, seen;
        set_hist(10, 1, 20, 4095);
        exp_divisor = 12'd4095;
        fixed_lat = 30;
        ds0 = ds_cnt;
        run_id = run_id + 1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (ds_cnt == ds0 && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        compared++;
        if (ds_cnt == ds0) begin mismatched++; $display("FAIL dwait_reach: div_start got 0 expected 1"); end
        repeat (3) @(negedge clk);
        compared++;
        if (busy !== 1'b1 || lut_we !== 1'b0) begin
            mismatched++;
            $display("FAIL dwait_hold: busy %b lut_we %b expected 1 and 0", busy, lut_we);
        end
        we0 = we_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        compared++;
        if ({busy, lut_we, div_start, done} !== 4'b0) begin
            mismatched++;
            $display("FAIL dwait_reset: got %b expected 0000", {busy, lut_we, div_start, done});
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (busy || lut_we) seen = 1'b1;
        end
        compared++;
        if (seen || we_cnt != we0) begin
            mismatched++;
            $display("FAIL late_done_ignored: activity %b writes %0d expected 0 and 0", seen, we_cnt - we0);
        end
        fixed_lat = 1;
        dn0 = done_cnt;
        run_build(5000, 0, 1'b0, cyc, b1, to);
        compared++;
        if (to || done_cnt - dn0 != 1) begin
            mismatched++;
            $display("FAIL rerun_done: done count %0d expected 1", done_cnt - dn0);
        end
        for (int i = 0; i < 256; i++) begin
            compared++;
            if (lut_mem[i] !== ((i >= 20) ? 8'd255 : 8'd0) || lut_stamp[i] != run_id) begin
                mismatched++;
                $display("FAIL rerun_lut[%0d]: got %0d expected %0d", i, lut_mem[i], (i >= 20) ? 255 : 0);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) hist_mem[i] = '0;
        test_reset();
        test_uniform();
        test_two_level();
        test_single_level();
        test_sparse();
        test_random_latency();
        test_reset_in_dwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
